gpr_wb_arbiter: RTL

- Shares the single GPR write port (write enable, 5-bit address, 32-bit data) between two requesters.
- Requester A is the in-order pipeline write-back stage: highest priority, never back-pressured.
- Requester B is a multi-cycle result source (divider / late memory return) with a valid/ready handshake, buffered in a small FIFO.
- Also supplies decode with per-register pending (busy) flags and a stall request that prevents B starvation.

---
 rtl/gpr_wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : gpr_wb_arbiter
// Purpose : Shares the single GPR write port between the in-order pipeline
//           write-back stage (A, highest priority, never back-pressured) and
//           a multi-cycle result source (B, valid/ready, buffered in a FIFO).
//           Also provides per-register pending flags for decode and a
//           one-cycle stall request that keeps B from starving.
// Ports   : clk, rst (sync, active-low)
//           a_we_i/a_addr_i/a_data_i      - pipeline write-back request
//           b_valid_i/b_ready_o/b_addr_i/b_data_i - B result handshake
//           rd_write_o/rd_addr_o/write_data_o     - GPR write port
//           q1_addr_i/q2_addr_i -> q1_busy_o/q2_busy_o - decode pending query
//           pipe_stall_o  - registered hold request for the pipeline
//           fifo_count_o  - FIFO occupancy (live or dead entries)
// Revision: 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_we_i,
  input  logic [4:0]               a_addr_i,
  input  logic [31:0]              a_data_i,
  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic [4:0]               b_addr_i,
  input  logic [31:0]              b_data_i,
  output logic                     rd_write_o,
  output logic [4:0]               rd_addr_o,
  output logic [31:0]              write_data_o,
  input  logic [4:0]               q1_addr_i,
  input  logic [4:0]               q2_addr_i,
  output logic                     q1_busy_o,
  output logic                     q2_busy_o,
  output logic                     pipe_stall_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [AW:0]   c_depth      = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT - 1);

  // FIFO storage; a cleared live bit marks an entry overwritten by a younger A
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [SW-1:0]    r_starve_cnt;
  logic             r_stall;

  logic w_not_empty;
  logic w_head_live;
  logic w_a_wins;
  logic w_grant_a;
  logic w_grant_b;
  logic w_pop;
  logic w_ready;
  logic w_push;
  logic w_push_live;
  logic w_q1_match;
  logic w_q2_match;

  assign w_not_empty = (r_count != '0);
  assign w_head_live = w_not_empty && r_live[r_rd_ptr];
  assign w_a_wins    = a_we_i && (a_addr_i != 5'd0);

  // A stall cycle hands the port to a live head even if A (illegally) writes
  assign w_grant_b = rst && w_head_live && (r_stall || !w_a_wins);
  assign w_grant_a = rst && w_a_wins && !(r_stall && w_head_live);

  // Dead heads drain silently; live heads leave only when written
  assign w_pop = rst && w_not_empty && (!r_live[r_rd_ptr] || w_grant_b);

  // Readiness uses registered occupancy only, so a same-cycle pop never
  // opens a slot while the FIFO is full
  assign w_ready     = rst && (r_count < c_depth);
  assign w_push      = w_ready && b_valid_i && (b_addr_i != 5'd0);
  // A same-cycle A write to the same register is younger: enqueue dead
  assign w_push_live = !(w_grant_a && (a_addr_i == b_addr_i));

  assign rd_write_o   = w_grant_a || w_grant_b;
  assign rd_addr_o    = w_grant_b ? r_addr[r_rd_ptr] : (w_grant_a ? a_addr_i : 5'd0);
  assign write_data_o = w_grant_b ? r_data[r_rd_ptr] : (w_grant_a ? a_data_i : 32'd0);
  assign b_ready_o    = w_ready;
  assign fifo_count_o = rst ? r_count : '0;
  assign pipe_stall_o = r_stall;

  // Live bits are only ever set on occupied slots, so no occupancy mask needed
  always_comb begin
    w_q1_match = 1'b0;
    w_q2_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_addr[i] == q1_addr_i)) w_q1_match = 1'b1;
      if (r_live[i] && (r_addr[i] == q2_addr_i)) w_q2_match = 1'b1;
    end
  end

  assign q1_busy_o = rst && (q1_addr_i != 5'd0) && w_q1_match;
  assign q2_busy_o = rst && (q2_addr_i != 5'd0) && w_q2_match;

  // Payload storage needs no reset: it is only observed through live bits
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= b_addr_i;
      r_data[r_wr_ptr] <= b_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      // WAW squash of every queued entry targeting the register A writes
      for (int i = 0; i < DEPTH; i++) begin
        if (w_grant_a && (r_addr[i] == a_addr_i)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + AW'(1);
      end
      // Push slot never aliases the pop slot: full blocks push, empty blocks pop
      if (w_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

      // Count consecutive losses of a live head; one stall pulse per limit hit
      if (w_grant_a && w_head_live) begin
        if (r_starve_cnt == c_starve_max) begin
          r_starve_cnt <= '0;
          r_stall      <= 1'b1;
        end else begin
          r_starve_cnt <= r_starve_cnt + SW'(1);
          r_stall      <= 1'b0;
        end
      end else begin
        r_starve_cnt <= '0;
        r_stall      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
